// File: rtl/vigna_mdu_arbiter_if.sv
// Bundle of the two requester ports and the shared multiply/divide unit port.
//   req0_* / req1_* : valid, func, op1, op2 from a requester; ready pulse and result back to it
//   mdu_*           : valid, func, op1, op2 to the shared unit; ready pulse and result from it
// Modports:
//   master : the arbiter (it masters the shared unit and answers the requesters)
//   slave  : the surroundings (requesters plus the shared unit)
interface vigna_mdu_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            req0_valid;
  logic [2:0]      req0_func;
  logic [XLEN-1:0] req0_op1;
  logic [XLEN-1:0] req0_op2;
  logic            req0_ready;
  logic [XLEN-1:0] req0_result;

  logic            req1_valid;
  logic [2:0]      req1_func;
  logic [XLEN-1:0] req1_op1;
  logic [XLEN-1:0] req1_op2;
  logic            req1_ready;
  logic [XLEN-1:0] req1_result;

  logic            mdu_valid;
  logic [2:0]      mdu_func;
  logic [XLEN-1:0] mdu_op1;
  logic [XLEN-1:0] mdu_op2;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_result;

  modport master (
    input  req0_valid, req0_func, req0_op1, req0_op2,
    output req0_ready, req0_result,
    input  req1_valid, req1_func, req1_op1, req1_op2,
    output req1_ready, req1_result,
    output mdu_valid, mdu_func, mdu_op1, mdu_op2,
    input  mdu_ready, mdu_result
  );

  modport slave (
    output req0_valid, req0_func, req0_op1, req0_op2,
    input  req0_ready, req0_result,
    output req1_valid, req1_func, req1_op1, req1_op2,
    input  req1_ready, req1_result,
    input  mdu_valid, mdu_func, mdu_op1, mdu_op2,
    output mdu_ready, mdu_result
  );
endinterface

// File: rtl/vigna_mdu_arbiter.sv
// Two-port round-robin arbiter sharing one vigna_m_ext multiply/divide unit.
// The winning request is latched and issued to the unit; the unit's result is
// returned to the granted requester with a one-cycle ready pulse. All outputs
// are registered.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : vigna_mdu_arbiter_if.master (requester ports and shared-unit port)
//   busy  : high whenever the arbiter is not idle
// Optional feature: define VIGNA_MDU_ARB_CACHE_EN to add a single-entry result
// cache that answers an exact repeat of the last unit operation without the unit.
module vigna_mdu_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  vigna_mdu_arbiter_if.master    bus,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q, state_d;
  logic            mdu_valid_q, mdu_valid_d;
  logic [2:0]      func_q, func_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic            gnt_q, gnt_d;
  logic            rr_q, rr_d;
  logic            rdy0_q, rdy0_d;
  logic            rdy1_q, rdy1_d;
  logic [XLEN-1:0] res0_q, res0_d;
  logic [XLEN-1:0] res1_q, res1_d;
  logic            busy_q, busy_d;

  // Request selection in IDLE: a lone requester wins, a tie goes to rr.
  logic            any_req;
  logic            sel_gnt;
  logic [2:0]      sel_func;
  logic [XLEN-1:0] sel_op1;
  logic [XLEN-1:0] sel_op2;
  logic            cache_hit;

  assign any_req  = bus.req0_valid | bus.req1_valid;
  assign sel_gnt  = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
  assign sel_func = sel_gnt ? bus.req1_func : bus.req0_func;
  assign sel_op1  = sel_gnt ? bus.req1_op1  : bus.req0_op1;
  assign sel_op2  = sel_gnt ? bus.req1_op2  : bus.req0_op2;

`ifdef VIGNA_MDU_ARB_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [2:0]      cache_func_q, cache_func_d;
  logic [XLEN-1:0] cache_op1_q, cache_op1_d;
  logic [XLEN-1:0] cache_op2_q, cache_op2_d;
  logic [XLEN-1:0] cache_res_q, cache_res_d;

  assign cache_hit = cache_vld_q && (cache_func_q == sel_func) &&
                     (cache_op1_q == sel_op1) && (cache_op2_q == sel_op2);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mdu_valid_d = mdu_valid_q;
    func_d      = func_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    rdy0_d      = 1'b0;
    rdy1_d      = 1'b0;
    res0_d      = res0_q;
    res1_d      = res1_q;
`ifdef VIGNA_MDU_ARB_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_func_d = cache_func_q;
    cache_op1_d  = cache_op1_q;
    cache_op2_d  = cache_op2_q;
    cache_res_d  = cache_res_q;
`endif

    case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d = sel_gnt;
          if (cache_hit) begin
`ifdef VIGNA_MDU_ARB_CACHE_EN
            if (sel_gnt) begin
              rdy1_d = 1'b1;
              res1_d = cache_res_q;
            end else begin
              rdy0_d = 1'b1;
              res0_d = cache_res_q;
            end
`endif
            rr_d    = ~sel_gnt;
            state_d = StResp;
          end else begin
            func_d      = sel_func;
            op1_d       = sel_op1;
            op2_d       = sel_op2;
            mdu_valid_d = 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.mdu_ready) begin
          mdu_valid_d = 1'b0;
          if (gnt_q) begin
            rdy1_d = 1'b1;
            res1_d = bus.mdu_result;
          end else begin
            rdy0_d = 1'b1;
            res0_d = bus.mdu_result;
          end
          rr_d    = ~gnt_q;
          state_d = StResp;
`ifdef VIGNA_MDU_ARB_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_func_d = func_q;
          cache_op1_d  = op1_q;
          cache_op2_d  = op2_q;
          cache_res_d  = bus.mdu_result;
`endif
        end
      end
      // One cycle here plus one in IDLE keeps mdu_valid low for the unit's wait state.
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mdu_valid_q <= 1'b0;
      func_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      rdy0_q      <= 1'b0;
      rdy1_q      <= 1'b0;
      res0_q      <= '0;
      res1_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdu_valid_q <= mdu_valid_d;
      func_q      <= func_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      rdy0_q      <= rdy0_d;
      rdy1_q      <= rdy1_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      busy_q      <= busy_d;
    end
  end

`ifdef VIGNA_MDU_ARB_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld_q  <= 1'b0;
      cache_func_q <= '0;
      cache_op1_q  <= '0;
      cache_op2_q  <= '0;
      cache_res_q  <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_func_q <= cache_func_d;
      cache_op1_q  <= cache_op1_d;
      cache_op2_q  <= cache_op2_d;
      cache_res_q  <= cache_res_d;
    end
  end
`endif

  assign bus.mdu_valid   = mdu_valid_q;
  assign bus.mdu_func    = func_q;
  assign bus.mdu_op1     = op1_q;
  assign bus.mdu_op2     = op2_q;
  assign bus.req0_ready  = rdy0_q;
  assign bus.req0_result = res0_q;
  assign bus.req1_ready  = rdy1_q;
  assign bus.req1_result = res1_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_vigna_mdu_arbiter.sv
// Self-checking bench for vigna_mdu_arbiter: directed requests, a behavioural
// shared unit, and a scoreboard monitor that checks every ready pulse in order.
module tb_vigna_mdu_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int MLAT = 3;           // model countdown; unit latency is MLAT+1 cycles
  localparam int ULAT = MLAT + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;

  vigna_mdu_arbiter_if #(.XLEN(XLEN)) bus ();

  vigna_mdu_arbiter #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] res;
  } exp_t;
  exp_t exp_q[$];

  task automatic expect_r(input int port, input logic [31:0] res);
    exp_t e;
    e.port = port;
    e.res  = res;
    exp_q.push_back(e);
  endtask

  // ---------------- shared unit model ----------------
  int          m_cnt;
  logic        m_wait;
  logic        m_stable;
  logic [2:0]  m_func;
  logic [31:0] m_a, m_b;

  function automatic logic [31:0] calc(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (f)
      3'd0:    return p[31:0];
      3'd3:    return p[63:32];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mdu_ready  <= 1'b0;
      bus.mdu_result <= '0;
      m_cnt          <= 0;
      m_wait         <= 1'b0;
      m_stable       <= 1'b1;
    end else begin
      bus.mdu_ready <= 1'b0;
      if (bus.mdu_ready) begin
        m_wait <= 1'b1;
      end else if (m_wait) begin
        m_wait <= 1'b0;
        chk("mdu_no_stale_valid", 32'(bus.mdu_valid), 0);
      end else if (m_cnt > 0) begin
        if (!bus.mdu_valid || bus.mdu_func != m_func || bus.mdu_op1 != m_a ||
            bus.mdu_op2 != m_b) m_stable <= 1'b0;
        if (m_cnt == 1) begin
          bus.mdu_ready  <= 1'b1;
          bus.mdu_result <= calc(m_func, m_a, m_b);
          chk("mdu_req_stable", (m_stable && bus.mdu_valid && bus.mdu_op1 == m_a &&
                                 bus.mdu_op2 == m_b && bus.mdu_func == m_func) ? 1 : 0, 1);
        end
        m_cnt <= m_cnt - 1;
      end else if (bus.mdu_valid) begin
        m_func   <= bus.mdu_func;
        m_a      <= bus.mdu_op1;
        m_b      <= bus.mdu_op2;
        m_stable <= 1'b1;
        m_cnt    <= MLAT;
      end
    end
  end

  // ---------------- monitor ----------------
  int   mv_cnt = 0;    // negedges with mdu_valid high
  int   low_cnt = 0;
  logic seen_done = 1'b0;
  logic prev_mv = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_done = 1'b0;
        low_cnt   = 0;
        prev_mv   = 1'b0;
      end else begin
        if (bus.mdu_valid) mv_cnt++;
        if (bus.mdu_valid && !prev_mv && seen_done)
          chk("mdu_valid_gap", (low_cnt >= 2) ? 1 : 0, 1);
        if (!bus.mdu_valid) low_cnt++;
        if (bus.mdu_ready) begin
          seen_done = 1'b1;
          low_cnt   = 0;
        end
        prev_mv = bus.mdu_valid;
        if (bus.req0_ready && bus.req1_ready)
          chk("ready_exclusive", 1, 0);
        if (bus.req0_ready || bus.req1_ready) begin
          int          port;
          logic [31:0] res;
          exp_t        e;
          port = bus.req1_ready ? 1 : 0;
          res  = bus.req1_ready ? bus.req1_result : bus.req0_result;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: port %0d result 0x%0h, none expected", port, res);
          end else begin
            e = exp_q.pop_front();
            chk("ready_port", port, e.port);
            chk("ready_result", res, e.res);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int port, input logic v, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      bus.req0_valid = v;
      bus.req0_func  = f;
      bus.req0_op1   = a;
      bus.req0_op2   = b;
    end else begin
      bus.req1_valid = v;
      bus.req1_func  = f;
      bus.req1_op1   = a;
      bus.req1_op2   = b;
    end
  endtask

  // Assert a request, wait (bounded) for its ready, drop valid in the ready cycle.
  task automatic run_req(input int port, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
    logic rdy;
    @(posedge clk);
    #1;
    drive(port, 1'b1, f, a, b);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
    end while (!rdy && cyc < 100);
    chk("req_timeout", (cyc < 100) ? 1 : 0, 1);
    drive(port, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mdu_valid"}, 32'(bus.mdu_valid), 0);
    chk({tag, "_mdu_func"}, 32'(bus.mdu_func), 0);
    chk({tag, "_mdu_op1"}, bus.mdu_op1, 0);
    chk({tag, "_mdu_op2"}, bus.mdu_op2, 0);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 0);
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 0);
    chk({tag, "_req0_result"}, bus.req0_result, 0);
    chk({tag, "_req1_result"}, bus.req1_result, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cyc2, mv0;
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Single MUL on port 0 with latency and issue checks.
    expect_r(0, 32'd42);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 3'd0, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    chk("issue_mdu_valid", 32'(bus.mdu_valid), 1);
    chk("issue_mdu_func", 32'(bus.mdu_func), 0);
    chk("issue_mdu_op1", bus.mdu_op1, 6);
    chk("issue_mdu_op2", bus.mdu_op2, 7);
    chk("issue_busy", 32'(busy), 1);
    cyc = 1;
    while (!bus.req0_ready && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mul_latency", cyc, ULAT + 2);
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);

    // MULHU on port 1.
    expect_r(1, 32'h0000_0001);
    run_req(1, 3'd3, 32'hFFFF_FFFF, 32'd2, cyc);
    chk("mulhu_latency", cyc, ULAT + 2);

    // Reset in the middle of an issued operation: dropped, no ready afterwards.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 3'd0, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    chk("pre_reset_mdu_valid", 32'(bus.mdu_valid), 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    expect_r(1, 32'd25);
    run_req(1, 3'd0, 32'd5, 32'd5, cyc);

    // Tie with rr=0: port 0 first. Port 1 then completes alone, which leaves rr=0.
    expect_r(0, 32'd15);
    expect_r(1, 32'd16);
    fork
      run_req(0, 3'd0, 32'd3, 32'd5, cyc);
      run_req(1, 3'd0, 32'd4, 32'd4, cyc2);
    join
    // A lone port-0 op flips rr to 1, so the next tie goes to port 1.
    expect_r(0, 32'd20);
    run_req(0, 3'd0, 32'd2, 32'd10, cyc);
    expect_r(1, 32'd16);
    expect_r(0, 32'd15);
    fork
      run_req(0, 3'd0, 32'd3, 32'd5, cyc);
      run_req(1, 3'd0, 32'd4, 32'd4, cyc2);
    join

    // Back-to-back on port 0; the monitor checks the mdu_valid gap.
    expect_r(0, 32'd9);
    run_req(0, 3'd0, 32'd3, 32'd3, cyc);
    expect_r(0, 32'd56);
    run_req(0, 3'd0, 32'd7, 32'd8, cyc);

    // Repeat of the same operation: answered from the cache when it is built.
    expect_r(0, 32'd42);
    run_req(0, 3'd0, 32'd6, 32'd7, cyc);
    mv0 = mv_cnt;
    expect_r(0, 32'd42);
    run_req(0, 3'd0, 32'd6, 32'd7, cyc);
`ifdef VIGNA_MDU_ARB_CACHE_EN
    chk("cache_hit_fast", (cyc <= 2) ? 1 : 0, 1);
    chk("cache_hit_no_mdu_valid", mv_cnt - mv0, 0);
`else
    chk("repeat_latency", cyc, ULAT + 2);
    chk("repeat_uses_unit", (mv_cnt > mv0) ? 1 : 0, 1);
`endif
    mv0 = mv_cnt;
    expect_r(0, 32'd48);
    run_req(0, 3'd0, 32'd6, 32'd8, cyc);
    chk("changed_op_uses_unit", (mv_cnt > mv0) ? 1 : 0, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
